// File: rtl/directory_memreq_arbiter_pkg.sv
// Shared types for the directory-bank memory request arbiter: the memory
// request payload, the grant selector and the legal prefetch ring depths.
package directory_memreq_arbiter_pkg;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [5:0]  src_id;
        logic [31:0] addr;
    } I_drtomem_req_type;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DEM  = 2'd1,
        GNT_PF   = 2'd2
    } grant_e;

    localparam int STARVE_W = 8;

    function automatic bit pf_depth_legal(input int depth);
        return (depth == 4) || (depth == 8) || (depth == 16);
    endfunction

endpackage

// File: rtl/directory_memreq_arbiter_dr_pf_ring.sv
// Drop-oldest prefetch ring: an enqueue into a full ring overwrites the head
// entry and reports it on o_overwrite so the owner can count the loss.
module directory_memreq_arbiter_dr_pf_ring
    import directory_memreq_arbiter_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enq,
    input  I_drtomem_req_type i_enq_data,
    input  logic              i_deq,
    input  logic              i_flush,
    output I_drtomem_req_type o_head,
    output logic [OCC_W-1:0]  o_count,
    output logic              o_overwrite
);

    I_drtomem_req_type r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [OCC_W-1:0]  r_count;

    logic w_full;
    logic w_wr_en;
    logic w_rd_adv;

    assign w_full      = (r_count == OCC_W'(DEPTH));
    assign w_wr_en     = i_enq && !i_flush;
    assign w_rd_adv    = !i_flush && (i_deq || (i_enq && w_full));
    assign o_overwrite = w_wr_en && w_full && !i_deq;
    assign o_head      = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    // NOTE: payload storage carries no reset; r_count gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_enq_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (i_enq && !i_deq && !w_full) begin
                r_count <= r_count + OCC_W'(1);
            end else if (i_deq && !i_enq) begin
                r_count <= r_count - OCC_W'(1);
            end
        end
    end

endmodule

// File: rtl/directory_memreq_arbiter.sv
// Shares the directory bank's drtomem_req channel between demand misses and a
// drop-oldest prefetch ring; demand wins unless prefetches have starved.
module directory_memreq_arbiter
    import directory_memreq_arbiter_pkg::*;
#(
    parameter  int PF_DEPTH   = 8,
    parameter  int STARVE_MAX = 16,
    parameter  int CNT_W      = 16,
    localparam int OCC_W      = $clog2(PF_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dem_valid,
    output logic              dem_retry,
    input  I_drtomem_req_type dem_req,
    input  logic              pf_valid,
    output logic              pf_retry,
    input  I_drtomem_req_type pf_req,
    input  logic              pf_flush,
    output logic              drtomem_req_valid,
    input  logic              drtomem_req_retry,
    output I_drtomem_req_type drtomem_req,
    output logic              pf_drop,
    output logic [CNT_W-1:0]  pf_drop_cnt,
    output logic [OCC_W-1:0]  pf_occupancy
);

    if (!pf_depth_legal(PF_DEPTH) || (STARVE_MAX < 1) || (STARVE_MAX > 255)) begin : g_bad_params
        $error("directory_memreq_arbiter: PF_DEPTH must be 4/8/16 and STARVE_MAX 1..255");
    end

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic                r_out_valid;
    I_drtomem_req_type   r_out_req;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_pf_drop;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic                w_load_en;
    logic                w_ring_nonempty;
    logic                w_force_pf;
    grant_e              w_grant;
    I_drtomem_req_type   w_pf_head;
    logic [OCC_W-1:0]    w_ring_count;
    logic                w_overwrite;

    directory_memreq_arbiter_dr_pf_ring #(
        .DEPTH (PF_DEPTH)
    ) u_dr_pf_ring (
        .clk         (clk),
        .reset       (reset),
        .i_enq       (pf_valid),
        .i_enq_data  (pf_req),
        .i_deq       (w_grant == GNT_PF),
        .i_flush     (pf_flush),
        .o_head      (w_pf_head),
        .o_count     (w_ring_count),
        .o_overwrite (w_overwrite)
    );

    assign w_load_en       = !r_out_valid || !drtomem_req_retry;
    assign w_ring_nonempty = (w_ring_count != '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_grant    = GNT_NONE;
        w_force_pf = 1'b0;
        if (w_load_en) begin
            if ((r_starve_cnt == STARVE_LIM) && w_ring_nonempty) begin
                w_grant    = GNT_PF;
                w_force_pf = 1'b1;
            end else if (dem_valid) begin
                w_grant = GNT_DEM;
            end else if (w_ring_nonempty) begin
                w_grant = GNT_PF;
            end
        end
    end

    // Depends only on registered state and drtomem_req_retry, never on dem_valid.
    assign dem_retry = !w_load_en || w_force_pf;
    assign pf_retry  = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (pf_flush || !w_ring_nonempty || (w_grant == GNT_PF)) begin
            r_starve_cnt <= '0;
        end else if ((w_grant == GNT_DEM) && (r_starve_cnt != STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_req   <= '0;
        end else if (w_load_en) begin
            r_out_valid <= (w_grant != GNT_NONE);
            if (w_grant == GNT_DEM) begin
                r_out_req <= dem_req;
            end else if (w_grant == GNT_PF) begin
                r_out_req <= w_pf_head;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pf_drop  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_pf_drop <= w_overwrite;
            if (w_overwrite && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign drtomem_req_valid = r_out_valid;
    assign drtomem_req       = r_out_req;
    assign pf_drop           = r_pf_drop;
    assign pf_drop_cnt       = r_drop_cnt;
    assign pf_occupancy      = w_ring_count;

endmodule
